disp_page_arbiter: RTL and testbench
====================================

DISP_PAGE_ARBITER -- requirements
Module: disp_page_arbiter

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 100_000_000, page display time in clk cycles (1 s at 100 MHz), minimum 2.
REQ-002 SHALL have parameter GAP_CYCLES, default 1_000_000, blank interval between pages in clk cycles (10 ms), minimum 1.
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz, rising edge.
REQ-004 SHALL have port button_reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  4  level request; req[i]=1 means requester i wants the display.
REQ-006 SHALL have ports data0..data3  input  32 each  8-digit BCD payload of requester i, with digit 7 in [31:28].
REQ-007 SHALL have port hold_pulse  input  1  single-cycle, already-debounced pulse that toggles page freeze.
REQ-008 SHALL have port display  output  32  payload for the digit scan unit.
REQ-009 SHALL have port disp_en  output  1  display enable, intended to be ANDed with the SW0 enable upstream.
REQ-010 SHALL have port grant  output  4  one-hot current owner; 0 when no owner.
REQ-011 SHALL have port page_idx  output  2  index of the last granted requester.
REQ-012 SHALL have port hold_active  output  1  freeze flag.
REQ-013 SHALL have port switch_pulse  output  1  one-cycle pulse on every entry to SHOW.

Function
REQ-014 SHALL implement FSM states IDLE, SHOW and GAP; grant, page_idx, hold_active, state and counters SHALL be registered.
REQ-015 display SHALL equal data of the granted requester, tracked live combinationally from registered grant, and SHALL be 0 when grant=0.
REQ-016 disp_en SHALL be 1 only in SHOW.
REQ-017 Arbitration SHALL be round-robin: scan indices page_idx+1, +2, +3, +4 (mod 4) and pick the first with req=1.
REQ-018 In IDLE, when any req=1, the FSM SHALL go to SHOW at the next edge with the arbitrated grant, so grant appears 1 cycle after req.
REQ-019 In SHOW, the dwell counter SHALL count 0..DWELL_CYCLES-1; at terminal count the FSM SHALL go to GAP if any other requester is active.
REQ-020 At terminal count, if no other requester is active, the FSM SHALL stay in SHOW with the same owner, reset the counter to 0, and SHALL NOT pulse switch_pulse.
REQ-021 If the granted requester's req drops in SHOW, the FSM SHALL go to GAP at the next edge regardless of the counter and SHALL clear hold_active.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles with grant=0; it SHALL then arbitrate into SHOW, or go to IDLE if req=0.
REQ-023 switch_pulse SHALL assert in the first SHOW cycle after IDLE or GAP.
REQ-024 hold_pulse SHALL toggle hold_active in any state.
REQ-025 While in SHOW with hold_active=1, the dwell counter SHALL freeze and rotation SHALL be suppressed.
REQ-026 If hold_pulse sets hold in the same cycle as the dwell terminal count, hold SHALL win: the counter stays at DWELL_CYCLES-1 and no rotation occurs.
REQ-027 When hold clears at terminal count, rotation SHALL occur at the next edge.
REQ-028 If req drops and hold_pulse arrive in the same cycle, the req drop SHALL win (go to GAP, hold_active=0).
REQ-029 Requests arriving during GAP SHALL be considered at GAP end only.
REQ-030 Counters SHALL be sized to ceil(log2(max(DWELL_CYCLES, GAP_CYCLES))) bits and SHALL never wrap past their terminal count.

Reset
REQ-031 On button_reset=1, the block SHALL asynchronously force IDLE, page_idx=3, both counters=0 and hold_active=0.
REQ-032 During reset, outputs SHALL be display=0, disp_en=0, grant=0, switch_pulse=0.
REQ-033 Reset asserted mid-SHOW or mid-GAP SHALL abort the page with no further output activity.
REQ-034 After reset release, the first grant SHALL go to the lowest-index active requester.

Verification (DWELL_CYCLES=8, GAP_CYCLES=2)
REQ-035 Bench SHALL drive reset then req=4'b0101 -> grant=0001 one cycle later with switch_pulse=1; after 8 cycles, 2 cycles of grant=0; then grant=0100.
REQ-036 Bench SHALL drive req=4'b0010 only for 30 cycles -> grant=0010 held throughout, disp_en=1 constant, exactly one switch_pulse.
REQ-037 Bench SHALL drive req=4'b0011, grant=0001, then drop req[0] at dwell count 3 -> grant=0 next cycle, then grant=0010 after 2 GAP cycles.
REQ-038 Bench SHALL drive hold_pulse at dwell count 7 with req=4'b1001 -> grant=0001 persists; a second hold_pulse 20 cycles later -> GAP next cycle, then grant=1000.
REQ-039 Bench SHALL change data0 from 32'h1234_5678 to 32'h0000_0030 while granted -> display follows in the same cycle; a req of 0 in GAP -> IDLE with display=0.
REQ-040 Bench SHALL assert button_reset mid-SHOW -> all outputs 0 immediately; after release with req=4'b1000 -> grant=1000.

Source files
------------

// File: rtl/disp_page_arbiter.sv
// Round-robin page arbiter for the 8-digit display: four requesters take turns
// owning the display for a dwell period, separated by a blank gap, with a freeze toggle.
module disp_page_arbiter #(
    parameter int unsigned DWELL_CYCLES = 100_000_000,
    parameter int unsigned GAP_CYCLES   = 1_000_000
) (
    input  logic        clk,
    input  logic        button_reset,
    input  logic [3:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [31:0] data3,
    input  logic        hold_pulse,
    output logic [31:0] display,
    output logic        disp_en,
    output logic [3:0]  grant,
    output logic [1:0]  page_idx,
    output logic        hold_active,
    output logic        switch_pulse
);

    localparam int unsigned MAX_CYCLES = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int unsigned CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    grant_nxt;
    logic [1:0]    page_idx_nxt;
    logic          hold_nxt;
    logic          pulse_nxt;
    logic [CW-1:0] dwell_cnt;
    logic [CW-1:0] dwell_nxt;
    logic [CW-1:0] gap_cnt;
    logic [CW-1:0] gap_nxt;

    logic          arb_found;
    logic [1:0]    arb_idx;
    logic [1:0]    cand;
    logic [3:0]    arb_grant;
    logic          owner_active;
    logic          others_active;

    // Round-robin scan starting just after the last granted requester.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = page_idx;
        cand      = '0;
        for (int unsigned k = 1; k < 5; k++) begin
            cand = page_idx + 2'(k);
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    assign arb_grant     = 4'b0001 << arb_idx;
    assign owner_active  = (req & grant) != '0;
    assign others_active = (req & ~grant) != '0;

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        page_idx_nxt = page_idx;
        hold_nxt     = hold_active ^ hold_pulse;
        pulse_nxt    = 1'b0;
        dwell_nxt    = dwell_cnt;
        gap_nxt      = gap_cnt;

        unique case (state)
            IDLE: begin
                if (arb_found) begin
                    state_nxt    = SHOW;
                    grant_nxt    = arb_grant;
                    page_idx_nxt = arb_idx;
                    dwell_nxt    = '0;
                    pulse_nxt    = 1'b1;
                end
            end

            SHOW: begin
                // The post-toggle hold value gates the counter, so a hold set
                // on the terminal cycle wins and a hold cleared there rotates.
                if (!owner_active) begin
                    state_nxt = GAP;
                    grant_nxt = '0;
                    hold_nxt  = 1'b0;
                    dwell_nxt = '0;
                    gap_nxt   = '0;
                end else if (!hold_nxt) begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_nxt = '0;
                        if (others_active) begin
                            state_nxt = GAP;
                            grant_nxt = '0;
                            gap_nxt   = '0;
                        end
                    end else begin
                        dwell_nxt = dwell_cnt + CW'(1);
                    end
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_nxt = '0;
                    if (arb_found) begin
                        state_nxt    = SHOW;
                        grant_nxt    = arb_grant;
                        page_idx_nxt = arb_idx;
                        dwell_nxt    = '0;
                        pulse_nxt    = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    gap_nxt = gap_cnt + CW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge button_reset) begin
        if (button_reset) begin
            state        <= IDLE;
            grant        <= '0;
            page_idx     <= 2'd3;
            hold_active  <= 1'b0;
            switch_pulse <= 1'b0;
            dwell_cnt    <= '0;
            gap_cnt      <= '0;
        end else begin
            state        <= state_nxt;
            grant        <= grant_nxt;
            page_idx     <= page_idx_nxt;
            hold_active  <= hold_nxt;
            switch_pulse <= pulse_nxt;
            dwell_cnt    <= dwell_nxt;
            gap_cnt      <= gap_nxt;
        end
    end

    always_comb begin
        display = '0;
        if (grant[0]) display = data0;
        if (grant[1]) display = data1;
        if (grant[2]) display = data2;
        if (grant[3]) display = data3;
    end

    assign disp_en = (state == SHOW);

endmodule

// File: tb/tb_disp_page_arbiter.sv
// Directed bench for disp_page_arbiter: per-cycle expectations are queued as
// stimulus is applied and popped one per clock for comparison.
module tb_disp_page_arbiter;

    localparam int unsigned DWELL = 8;
    localparam int unsigned GAPC  = 2;

    logic        clk = 1'b0;
    logic        button_reset;
    logic [3:0]  req;
    logic [31:0] data0, data1, data2, data3;
    logic        hold_pulse;
    logic [31:0] display;
    logic        disp_en;
    logic [3:0]  grant;
    logic [1:0]  page_idx;
    logic        hold_active;
    logic        switch_pulse;

    disp_page_arbiter #(
        .DWELL_CYCLES(DWELL),
        .GAP_CYCLES  (GAPC)
    ) dut (
        .clk         (clk),
        .button_reset(button_reset),
        .req         (req),
        .data0       (data0),
        .data1       (data1),
        .data2       (data2),
        .data3       (data3),
        .hold_pulse  (hold_pulse),
        .display     (display),
        .disp_en     (disp_en),
        .grant       (grant),
        .page_idx    (page_idx),
        .hold_active (hold_active),
        .switch_pulse(switch_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] g;
        logic       p;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    string cur_tag  = "init";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model_display(input logic [3:0] gnt);
        logic [31:0] d;
        d = '0;
        if (gnt == 4'b0001) d = data0;
        if (gnt == 4'b0010) d = data1;
        if (gnt == 4'b0100) d = data2;
        if (gnt == 4'b1000) d = data3;
        return d;
    endfunction

    task automatic expect_cycles(input logic [3:0] gnt, input logic pls, input int n);
        exp_t e;
        e.g = gnt;
        e.p = pls;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({cur_tag, ":grant"},   32'(grant),        32'(e.g));
            check({cur_tag, ":disp_en"}, 32'(disp_en),      32'(e.g != 4'b0000));
            check({cur_tag, ":pulse"},   32'(switch_pulse), 32'(e.p));
            check({cur_tag, ":display"}, display,           model_display(e.g));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        button_reset = 1'b1;
        req          = 4'b0000;
        hold_pulse   = 1'b0;
        data0        = 32'h1234_5678;
        data1        = 32'h1111_1111;
        data2        = 32'h2222_2222;
        data3        = 32'h3333_3333;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst:grant",    32'(grant),        32'h0);
        check("rst:display",  display,           32'h0);
        check("rst:disp_en",  32'(disp_en),      32'h0);
        check("rst:pulse",    32'(switch_pulse), 32'h0);
        check("rst:page_idx", 32'(page_idx),     32'h3);
        check("rst:hold",     32'(hold_active),  32'h0);

        // Two requesters: lowest index first, dwell, gap, rotate
        cur_tag = "rr";
        button_reset = 1'b0;
        req = 4'b0101;
        expect_cycles(4'b0001, 1'b1, 1);
        expect_cycles(4'b0001, 1'b0, DWELL - 1);
        expect_cycles(4'b0000, 1'b0, GAPC);
        expect_cycles(4'b0100, 1'b1, 1);
        run(1 + DWELL + GAPC);
        check("rr:page_idx", 32'(page_idx), 32'h2);

        // Single requester keeps the display without re-pulsing
        cur_tag = "to_idle1";
        req = 4'b0000;
        expect_cycles(4'b0000, 1'b0, GAPC + 1);
        run(GAPC + 1);
        cur_tag = "single";
        req = 4'b0010;
        expect_cycles(4'b0010, 1'b1, 1);
        expect_cycles(4'b0010, 1'b0, 29);
        run(30);
        check("single:page_idx", 32'(page_idx), 32'h1);

        // Owner drops request mid-dwell
        cur_tag = "to_idle2";
        req = 4'b0000;
        expect_cycles(4'b0000, 1'b0, GAPC + 1);
        run(GAPC + 1);
        cur_tag = "drop";
        req = 4'b0011;
        expect_cycles(4'b0001, 1'b1, 1);
        expect_cycles(4'b0001, 1'b0, 3);
        run(4);
        req = 4'b0010;
        expect_cycles(4'b0000, 1'b0, GAPC);
        expect_cycles(4'b0010, 1'b1, 1);
        run(GAPC + 1);

        // Hold set on the terminal count, released 20 cycles later
        cur_tag = "to_idle3";
        req = 4'b0000;
        expect_cycles(4'b0000, 1'b0, GAPC + 1);
        run(GAPC + 1);
        cur_tag = "hold";
        req = 4'b0001;
        expect_cycles(4'b0001, 1'b1, 1);
        run(1);
        req = 4'b1001;
        expect_cycles(4'b0001, 1'b0, DWELL - 1);
        run(DWELL - 1);
        hold_pulse = 1'b1;
        expect_cycles(4'b0001, 1'b0, 1);
        run(1);
        hold_pulse = 1'b0;
        check("hold:set", 32'(hold_active), 32'h1);
        expect_cycles(4'b0001, 1'b0, 19);
        run(19);
        check("hold:still", 32'(hold_active), 32'h1);
        hold_pulse = 1'b1;
        expect_cycles(4'b0000, 1'b0, 1);
        run(1);
        hold_pulse = 1'b0;
        check("hold:clear", 32'(hold_active), 32'h0);
        expect_cycles(4'b0000, 1'b0, GAPC - 1);
        expect_cycles(4'b1000, 1'b1, 1);
        run(GAPC);
        check("hold:page_idx", 32'(page_idx), 32'h3);

        // Request drop and hold pulse together: drop wins
        cur_tag = "drop_hold";
        req = 4'b0001;
        hold_pulse = 1'b1;
        expect_cycles(4'b0000, 1'b0, 1);
        run(1);
        hold_pulse = 1'b0;
        check("drop_hold:hold", 32'(hold_active), 32'h0);
        expect_cycles(4'b0000, 1'b0, GAPC - 1);
        expect_cycles(4'b0001, 1'b1, 1);
        run(GAPC);

        // Display tracks payload combinationally; gap with no request goes idle
        check("live:before", display, 32'h1234_5678);
        data0 = 32'h0000_0030;
        #1;
        check("live:after", display, 32'h0000_0030);
        cur_tag = "gap_idle";
        req = 4'b0000;
        expect_cycles(4'b0000, 1'b0, GAPC + 1);
        run(GAPC + 1);
        check("gap_idle:display", display, 32'h0);

        // Reset mid-SHOW with hold active
        cur_tag = "pre_rst";
        req = 4'b0100;
        expect_cycles(4'b0100, 1'b1, 1);
        run(1);
        hold_pulse = 1'b1;
        expect_cycles(4'b0100, 1'b0, 1);
        run(1);
        hold_pulse = 1'b0;
        expect_cycles(4'b0100, 1'b0, 1);
        run(1);
        check("pre_rst:hold", 32'(hold_active), 32'h1);
        #2;
        button_reset = 1'b1;
        #1;
        check("mid_rst:grant",    32'(grant),        32'h0);
        check("mid_rst:display",  display,           32'h0);
        check("mid_rst:disp_en",  32'(disp_en),      32'h0);
        check("mid_rst:pulse",    32'(switch_pulse), 32'h0);
        check("mid_rst:page_idx", 32'(page_idx),     32'h3);
        check("mid_rst:hold",     32'(hold_active),  32'h0);
        req = 4'b1000;
        repeat (2) @(posedge clk);
        #1;
        check("in_rst:grant", 32'(grant), 32'h0);
        cur_tag = "post_rst";
        button_reset = 1'b0;
        expect_cycles(4'b1000, 1'b1, 1);
        expect_cycles(4'b1000, 1'b0, 1);
        run(2);

        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
